// File: rtl/bus_arbiter_mux_if.sv
// ============================================================================
// Module      : bus_arbiter_mux_if
// Description : Source/bus bundle for bus_arbiter_mux; the optional conflict_cnt
//               member exists only when CONFLICT_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_arbiter_mux_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 24,
    parameter int SEL_W   = $clog2(NUM_SRC)
);
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_req;
    logic                     bus_en;
    logic [WIDTH-1:0]         bus_out;
    logic                     bus_valid;
    logic [NUM_SRC-1:0]       grant;
    logic [SEL_W-1:0]         grant_idx;
    logic                     conflict;
    logic                     conflict_sticky;
`ifdef CONFLICT_CNT_EN
    logic [15:0]              conflict_cnt;
`endif

    modport master (
        output src_data, src_req, bus_en,
        input  bus_out, bus_valid, grant, grant_idx, conflict, conflict_sticky
`ifdef CONFLICT_CNT_EN
        , input conflict_cnt
`endif
    );

    modport slave (
        input  src_data, src_req, bus_en,
        output bus_out, bus_valid, grant, grant_idx, conflict, conflict_sticky
`ifdef CONFLICT_CNT_EN
        , output conflict_cnt
`endif
    );
endinterface

`default_nettype wire

// File: rtl/bus_arbiter_mux.sv
// ============================================================================
// Module      : bus_arbiter_mux
// Description : Registered round-robin arbitrated bus multiplexer with conflict
//               flagging. Optional macro CONFLICT_CNT_EN adds a 16-bit saturating
//               conflict counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_mux #(
    parameter int WIDTH     = 32,
    parameter int NUM_SRC   = 24,
    parameter int HOLD_LAST = 0
) (
    input  wire                 clock_i,
    input  wire                 clear_i,
    bus_arbiter_mux_if.slave    bus
);
    localparam int SEL_W = $clog2(NUM_SRC);
    localparam logic [SEL_W:0]   NUM_W  = (SEL_W+1)'(NUM_SRC);
    localparam logic [SEL_W-1:0] LAST_W = SEL_W'(NUM_SRC - 1);

    logic [WIDTH-1:0]   bus_out_q,   bus_out_d;
    logic               bus_valid_q, bus_valid_d;
    logic [NUM_SRC-1:0] grant_q,     grant_d;
    logic [SEL_W-1:0]   grant_idx_q, grant_idx_d;
    logic               conflict_q,  conflict_d;
    logic               sticky_q,    sticky_d;
    logic [SEL_W-1:0]   ptr_q,       ptr_d;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W:0]     cand;
    logic               seen_one;
    logic               multi_req;
    logic [WIDTH-1:0]   win_data;

    // Rotating scan starting at ptr_q; the first requester encountered wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
            if (cand >= NUM_W) begin
                cand = cand - NUM_W;
            end
            if (!win_found && bus.src_req[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        seen_one  = 1'b0;
        multi_req = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.src_req[i]) begin
                if (seen_one) begin
                    multi_req = 1'b1;
                end
                seen_one = 1'b1;
            end
        end
    end

    assign win_data = bus.src_data[win_idx*WIDTH +: WIDTH];

    always_comb begin
        bus_out_d   = bus_out_q;
        bus_valid_d = bus_valid_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        conflict_d  = conflict_q;
        sticky_d    = sticky_q;
        ptr_d       = ptr_q;
        if (bus.bus_en) begin
            conflict_d = multi_req;
            sticky_d   = sticky_q | multi_req;
            if (win_found) begin
                bus_out_d   = win_data;
                bus_valid_d = 1'b1;
                grant_d     = NUM_SRC'(1) << win_idx;
                grant_idx_d = win_idx;
                ptr_d       = (win_idx == LAST_W) ? '0 : win_idx + SEL_W'(1);
            end else begin
                bus_out_d   = (HOLD_LAST != 0) ? bus_out_q : '0;
                bus_valid_d = 1'b0;
                grant_d     = '0;
                grant_idx_d = '0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            bus_out_q   <= '0;
            bus_valid_q <= 1'b0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            conflict_q  <= 1'b0;
            sticky_q    <= 1'b0;
            ptr_q       <= '0;
        end else begin
            bus_out_q   <= bus_out_d;
            bus_valid_q <= bus_valid_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            conflict_q  <= conflict_d;
            sticky_q    <= sticky_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.bus_out         = bus_out_q;
    assign bus.bus_valid       = bus_valid_q;
    assign bus.grant           = grant_q;
    assign bus.grant_idx       = grant_idx_q;
    assign bus.conflict        = conflict_q;
    assign bus.conflict_sticky = sticky_q;

`ifdef CONFLICT_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturates instead of wrapping so a long storm never reads back as "few".
    always_comb begin
        cnt_d = cnt_q;
        if (bus.bus_en && multi_req && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (clear_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.conflict_cnt = cnt_q;
`endif

endmodule

`default_nettype wire
